// File: rtl/binary_frame_packer.sv
// binary_frame_packer
//
// Packs a binary pixel stream (0x00/0xFF per pixel) into bytes for the
// dual-port image RAM, eight pixels per byte with the earliest pixel in the
// MSB. The RAM read side unpacks bit ~addr[2:0], so this ordering must hold.
//
// Ports:
//   clk         pixel clock
//   rst         asynchronous, active-high reset
//   pix_valid   input_data / pix_sof qualifier
//   pix_sof     marks the first pixel of a frame (only with pix_valid)
//   input_data  binary pixel, bit 7 carries the value
//   wraddress   RAM word address of the current write
//   data        packed byte for the RAM
//   wren        one-cycle RAM write strobe per completed byte
//   busy        high while a frame is being packed
//   frame_done  one-cycle pulse alongside the last write of a frame
//   frame_err   one-cycle pulse when a frame restarts before completion
module binary_frame_packer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [7:0]        input_data,
  output logic [ADDR_W-1:0] wraddress,
  output logic [7:0]        data,
  output logic              wren,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int WORDS = H_RES * V_RES / 8;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0]        state;
  logic [2:0]        bit_cnt;
  logic [6:0]        shift;
  logic [ADDR_W-1:0] word_cnt;
  logic              pix;

  // Only bit 7 carries the pixel value.
  logic unused_bits;
  assign unused_bits = ^input_data[6:0];
  assign pix         = input_data[7];

  assign busy = (state == ACTIVE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 7'd0;
      word_cnt   <= '0;
      wraddress  <= '0;
      data       <= 8'h00;
      wren       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // Strobes default low; data/wraddress hold between writes.
      wren       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (pix_valid) begin
        case (state)
          IDLE: begin
            // Pixels before the first start-of-frame are dropped.
            if (pix_sof) begin
              state    <= ACTIVE;
              shift    <= {6'd0, pix};
              bit_cnt  <= 3'd1;
              word_cnt <= '0;
            end
          end
          default: begin
            if (pix_sof) begin
              // Resync: the partial byte is discarded and the frame restarts
              // with this pixel as bit 7 of word 0.
              frame_err <= 1'b1;
              shift     <= {6'd0, pix};
              bit_cnt   <= 3'd1;
              word_cnt  <= '0;
            end else if (bit_cnt == 3'd7) begin
              data      <= {shift, pix};
              wraddress <= word_cnt;
              wren      <= 1'b1;
              bit_cnt   <= 3'd0;
              if (word_cnt == LAST_WORD) begin
                word_cnt   <= '0;
                state      <= IDLE;
                frame_done <= 1'b1;
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end else begin
              shift   <= {shift[5:0], pix};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        endcase
      end
    end
  end

endmodule
